credit_receiver: RTL and testbench
==================================

// Module: credit_receiver
// PURPOSE
//  Downstream endpoint of a credit link: consumes data/valid/credit traffic arriving from a
//  credit_interconnect_reg chain, buffers words in a DEPTH-entry FIFO, presents them to the
//  consuming pearl over a valid/ready handshake, and returns one credit per dequeued word
//  back upstream on o_increment_count. Upstream sender holds DEPTH credits out of reset.
// PARAMETERS
//  DATA_WIDTH  32  payload bits per word
//  DEPTH       8   FIFO entries = credits issued to sender; power of 2, >= 2
// PORTS
//  clock              in   1           single clock, all logic posedge
//  resetn             in   1           asynchronous, active-low reset
//  i_data             in   DATA_WIDTH  word from link (last interconnect reg)
//  i_valid            in   1           i_data valid this cycle; push into FIFO
//  o_increment_count  out  1           one-cycle pulse = one credit returned upstream
//  o_data             out  DATA_WIDTH  head-of-FIFO word to pearl
//  o_valid            out  1           o_data valid (FIFO non-empty)
//  i_ready            in   1           pearl accepts o_data this cycle
//  o_overflow         out  1           sticky: word arrived with FIFO full and no pop
// BEHAVIOUR
//  - Reset (resetn=0, async assert, sync deassert at source): wr_ptr=rd_ptr=0, count=0,
//    o_valid=0, o_increment_count=0, o_overflow=0; o_data=0 (storage not cleared).
//  - push = i_valid; pop = o_valid & i_ready. No backpressure toward link: credits are
//    the only flow control.
//  - Show-ahead FIFO: o_data = mem[rd_ptr], o_valid = (count != 0). Both registered state,
//    no combinational path i_valid->o_valid: word written at edge N visible at N+1.
//  - count: +1 push only, -1 pop only, unchanged push&pop. Width $clog2(DEPTH+1).
//  - Pointers $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
//  - Credit return: o_increment_count <= pop (registered, exactly one pulse per pop, one
//    cycle after the pop edge). Never pulses while resetn=0 or for dropped words.
//  - Full (count==DEPTH): push&pop same cycle legal -> write to freed slot, count stays
//    DEPTH. push without pop -> word dropped, pointers/count unchanged, o_overflow<=1
//    and holds until reset (protocol violation indicator, sender over-ran credits).
//  - Empty: pop impossible (o_valid=0); i_ready ignored. push on empty -> o_valid next cycle.
//  - Reset mid-operation: buffered words discarded, no credits returned for them; sender
//    must share resetn so its credit counter returns to DEPTH in the same cycle.
//  - Invariant (checked by assertion): count + credits_in_flight + sender_credits == DEPTH.
// STRUCTURE
//  - credit_pkg: localparam helpers cnt_width(DEPTH)=$clog2(DEPTH+1),
//    ptr_width(DEPTH)=$clog2(DEPTH); typedef for credit pulse struct {valid, incr}
//    shared with credit_sender and credit_interconnect_reg.
//  - One sub-module: credit_fifo_mem (DEPTH x DATA_WIDTH storage, 1 write port, async
//    read port at rd_ptr, no reset on array). Pointers, count, credit, overflow in top.
//  - Elaboration-time check: DEPTH power of 2 and >= 2, else $error.
// TESTING
//  1. Reset then 3 pushes (0xA1,0xA2,0xA3), i_ready=0 -> o_valid=1 from cycle after
//     first push, o_data=0xA1, count=3, o_increment_count never pulses.
//  2. Then i_ready=1 for 3 cycles -> o_data 0xA1,0xA2,0xA3 in order; 3 credit pulses, each
//     one cycle after its pop; o_valid=0 after third pop.
//  3. DEPTH=8: 8 pushes, i_ready=0 -> count=8; 9th push without pop -> dropped,
//     o_overflow=1 sticky, head still first word; 9th push with concurrent pop -> accepted,
//     no overflow.
//  4. Streaming push&pop every cycle for 20 words (wraps pointers twice) -> in-order output,
//     count constant, 20 credit pulses, o_overflow=0.
//  5. Assert resetn=0 mid-stream with count=5 -> immediately o_valid=0,
//     o_increment_count=0; after release FIFO empty, no credits emitted for the 5 words.
//  6. Random bench with model credit_sender + 3 credit_interconnect_reg stages each way,
//     random i_ready -> scoreboard exact data order, credit invariant holds, no overflow.

Source files
------------

// File: rtl/credit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : credit_pkg
// Brief    : Shared width helpers and credit pulse type for the credit link.
// Revision : 1.0 - initial release
// ============================================================================
package credit_pkg;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic valid;
        logic incr;
    } credit_pulse_t;

endpackage
`default_nettype wire

// File: rtl/credit_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : credit_fifo_mem
// Brief    : DEPTH x DATA_WIDTH storage, one write port, async read port.
// Revision : 1.0 - initial release
// ============================================================================
module credit_fifo_mem
    import credit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    localparam int c_PTR_W   = ptr_width(DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [c_PTR_W-1:0]    wr_ptr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [c_PTR_W-1:0]    rd_ptr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // No reset on the array: contents are only meaningful behind the count.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/credit_receiver.sv
`default_nettype none
// ============================================================================
// Module   : credit_receiver
// Brief    : Credit-link endpoint: show-ahead FIFO plus one credit per pop.
// Revision : 1.0 - initial release
// ============================================================================
module credit_receiver
    import credit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_increment_count,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_overflow
);

    localparam int                 c_PTR_W = ptr_width(DEPTH);
    localparam int                 c_CNT_W = cnt_width(DEPTH);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("credit_receiver: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_incr;
    logic                  r_overflow;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DATA_WIDTH-1:0] w_head;

    assign o_valid = (r_count != '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = o_valid & i_ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    assign w_push  = i_valid & (~w_full | w_pop);
    assign w_drop  = i_valid & w_full & ~w_pop;

    assign o_data            = o_valid ? w_head : '0;
    assign o_increment_count = r_incr;
    assign o_overflow        = r_overflow;

    credit_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (w_push),
        .wr_ptr  (r_wr_ptr),
        .wr_data (i_data),
        .rd_ptr  (r_rd_ptr),
        .rd_data (w_head)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_incr     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_incr <= w_pop;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_credit_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_credit_receiver
// Brief    : Scoreboard bench for credit_receiver with a sender/link model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_credit_receiver;

    localparam int DW     = 32;
    localparam int DEPTH  = 8;
    localparam int STAGES = 3;

    logic          clock  = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    logic          o_increment_count;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_overflow;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [DW-1:0] sb[$];
    bit            m_ovf = 1'b0;

    // Sender plus link register model used by the random phase.
    int            credits;
    logic          fwd_v [STAGES];
    logic [DW-1:0] fwd_d [STAGES];
    logic          ret   [STAGES];

    always #5 clock = ~clock;

    credit_receiver #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clock             (clock),
        .resetn            (resetn),
        .i_data            (i_data),
        .i_valid           (i_valid),
        .o_increment_count (o_increment_count),
        .o_data            (o_data),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_overflow        (o_overflow)
    );

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already applied; advances one cycle.
    task automatic tick();
        bit full;
        bit pop;
        full = (sb.size() == DEPTH);
        pop  = (sb.size() != 0) && i_ready;
        if (pop) begin
            chk(64'(o_data), 64'(sb[0]), "pop_data");
            void'(sb.pop_front());
        end
        if (i_valid) begin
            if (!full || pop) sb.push_back(i_data);
            else              m_ovf = 1'b1;
        end
        @(posedge clock);
        @(negedge clock);
        chk(64'(o_increment_count), 64'(pop), "credit_pulse");
        chk(64'(o_valid), 64'(sb.size() != 0), "valid");
        chk(64'(o_overflow), 64'(m_ovf), "overflow");
        if (sb.size() != 0) chk(64'(o_data), 64'(sb[0]), "head_data");
    endtask

    // Asynchronous assert between edges; outputs must clear without a clock.
    task automatic do_reset();
        #2 resetn = 1'b0;
        #1;
        chk(64'(o_valid), 64'd0, "rst_valid");
        chk(64'(o_increment_count), 64'd0, "rst_credit");
        chk(64'(o_overflow), 64'd0, "rst_overflow");
        chk(64'(o_data), 64'd0, "rst_data");
        sb.delete();
        m_ovf   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        int            sum;
        bit            send;
        logic [DW-1:0] sd;
        logic          incr_b;

        // Reset state
        repeat (2) @(negedge clock);
        chk(64'(o_valid), 64'd0, "init_valid");
        chk(64'(o_increment_count), 64'd0, "init_credit");
        chk(64'(o_overflow), 64'd0, "init_overflow");
        chk(64'(o_data), 64'd0, "init_data");
        resetn = 1'b1;
        @(negedge clock);

        // Three pushes, no pops
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data = 32'hA1; tick();
        i_data = 32'hA2; tick();
        i_data = 32'hA3; tick();
        i_valid = 1'b0;

        // Drain in order
        i_ready = 1'b1;
        repeat (4) tick();

        // Fill to DEPTH, then full with and without a concurrent pop
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            i_data = 32'hB0 + i;
            tick();
        end
        i_data = 32'hC1; i_ready = 1'b1; tick();
        chk(64'(o_overflow), 64'd0, "full_pushpop_no_ovf");
        i_data = 32'hC2; i_ready = 1'b0; tick();
        chk(64'(o_overflow), 64'd1, "full_drop_ovf");
        chk(64'(o_data), 64'hB1, "full_drop_head");
        i_valid = 1'b0; tick();
        i_ready = 1'b1;
        repeat (DEPTH + 1) tick();
        chk(64'(o_overflow), 64'd1, "ovf_sticky");
        do_reset();

        // Streaming push and pop every cycle across pointer wraps
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data = 32'hD0; tick();
        i_data = 32'hD1; tick();
        i_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            i_data = 32'hE00 + i;
            tick();
        end
        i_valid = 1'b0;
        repeat (3) tick();

        // Reset while five words are buffered and a credit is outstanding
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_data = 32'hF0 + i;
            tick();
        end
        i_data = 32'hF5; i_ready = 1'b1; tick();
        i_valid = 1'b0; i_ready = 1'b0;
        do_reset();
        i_ready = 1'b1;
        repeat (3) tick();
        do_reset();

        // Random traffic through sender and link stages
        credits = DEPTH;
        for (int s = 0; s < STAGES; s++) begin
            fwd_v[s] = 1'b0;
            fwd_d[s] = '0;
            ret[s]   = 1'b0;
        end
        for (int cyc = 0; cyc < 500; cyc++) begin
            send    = (cyc < 450) && (credits > 0) && ($urandom_range(0, 3) != 0);
            sd      = $urandom;
            i_valid = fwd_v[STAGES-1];
            i_data  = fwd_d[STAGES-1];
            i_ready = (cyc >= 450) || ($urandom_range(0, 9) < 7);
            sum = credits + sb.size() + int'(o_increment_count);
            for (int s = 0; s < STAGES; s++) sum += int'(fwd_v[s]) + int'(ret[s]);
            chk(64'(sum), 64'(DEPTH), "credit_invariant");
            incr_b = o_increment_count;
            tick();
            credits = credits - int'(send) + int'(ret[STAGES-1]);
            for (int s = STAGES - 1; s > 0; s--) begin
                ret[s]   = ret[s-1];
                fwd_v[s] = fwd_v[s-1];
                fwd_d[s] = fwd_d[s-1];
            end
            ret[0]   = incr_b;
            fwd_v[0] = send;
            fwd_d[0] = sd;
        end
        chk(64'(credits), 64'(DEPTH), "final_credits");
        chk(64'(sb.size()), 64'd0, "final_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
